// File: rtl/std_cache_pkg.sv
// Shared data-cache types: flush sequencer states and address-width derivation.
// Optional feature (in the flush controller): DCACHE_FLUSH_PERF_CNT_EN.
package std_cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LATCH,
    WB,
    INV,
    DONE
  } flush_state_e;

  function automatic int calc_index_bits(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int calc_offset_bits(input int line_width);
    return $clog2(line_width / 8);
  endfunction

  function automatic int calc_addr_width(input int tag_width, input int num_sets,
                                         input int line_width);
    return tag_width + calc_index_bits(num_sets) + calc_offset_bits(line_width);
  endfunction

endpackage

// File: rtl/dcache_flush_way_sel.sv
// Find-first-set over the pending writeback mask; lowest way wins.
// Latency: purely combinational.
// Backpressure: none, pure decode.
module dcache_flush_way_sel #(
  parameter int NUM_WAYS = 8,
  localparam int WAY_BITS = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic [NUM_WAYS-1:0] pending,
  output logic [WAY_BITS-1:0] way_idx,
  output logic                any_set
);

  always_comb begin
    way_idx = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (pending[i]) way_idx = WAY_BITS'(i);
    end
    any_set = |pending;
  end

endmodule

// File: rtl/dcache_flush_ctrl.sv
// Flush sequencer: per set read all ways, write back valid+dirty lines, invalidate the set.
// Latency: 3 cycles per set plus one per dirty line when grant/ready are immediate.
// Backpressure: holds req_o until gnt_i and wb_valid_o/payload until wb_ready_i. Macro DCACHE_FLUSH_PERF_CNT_EN adds wb_count_o.
module dcache_flush_ctrl
  import std_cache_pkg::*;
#(
  parameter int SET_ASSOC  = 8,
  parameter int NUM_SETS   = 256,
  parameter int LINE_WIDTH = 128,
  parameter int TAG_WIDTH  = 44,
  localparam int INDEX_BITS  = calc_index_bits(NUM_SETS),
  localparam int OFFSET_BITS = calc_offset_bits(LINE_WIDTH),
  localparam int ADDR_WIDTH  = calc_addr_width(TAG_WIDTH, NUM_SETS, LINE_WIDTH)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            flush_i,
  output logic                            flush_ack_o,
  output logic                            busy_o,
  output logic [SET_ASSOC-1:0]            req_o,
  output logic [INDEX_BITS-1:0]           addr_o,
  output logic                            we_o,
  input  logic                            gnt_i,
  input  logic [SET_ASSOC-1:0]            line_valid_i,
  input  logic [SET_ASSOC-1:0]            line_dirty_i,
  input  logic [SET_ASSOC*TAG_WIDTH-1:0]  line_tag_i,
  input  logic [SET_ASSOC*LINE_WIDTH-1:0] line_data_i,
  output logic                            wb_valid_o,
  input  logic                            wb_ready_i,
  output logic [ADDR_WIDTH-1:0]           wb_addr_o,
  output logic [LINE_WIDTH-1:0]           wb_data_o
`ifdef DCACHE_FLUSH_PERF_CNT_EN
  ,
  output logic [31:0]                     wb_count_o
`endif
);

  localparam int WAY_BITS = (SET_ASSOC > 1) ? $clog2(SET_ASSOC) : 1;

  flush_state_e            state_q, state_d;
  logic [INDEX_BITS-1:0]   index_q;
  logic [SET_ASSOC-1:0]    pending_q;
  logic [SET_ASSOC-1:0]    pending_rest;
  logic [TAG_WIDTH-1:0]    tag_q  [SET_ASSOC];
  logic [LINE_WIDTH-1:0]   data_q [SET_ASSOC];
  logic [WAY_BITS-1:0]     way_idx;
  logic                    way_any;
  logic                    last_set;

  dcache_flush_way_sel #(
    .NUM_WAYS(SET_ASSOC)
  ) u_way_sel (
    .pending(pending_q),
    .way_idx(way_idx),
    .any_set(way_any)
  );

  assign pending_rest = pending_q & ~(SET_ASSOC'(1) << way_idx);
  assign last_set     = (index_q == INDEX_BITS'(NUM_SETS - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    req_o       = '0;
    we_o        = 1'b0;
    wb_valid_o  = 1'b0;
    flush_ack_o = 1'b0;
    busy_o      = (state_q != IDLE);
    case (state_q)
      IDLE:  if (flush_i) state_d = READ;
      READ: begin
        req_o = '1;
        if (gnt_i) state_d = LATCH;
      end
      LATCH: state_d = (|(line_valid_i & line_dirty_i)) ? WB : INV;
      WB: begin
        wb_valid_o = way_any;
        if (wb_ready_i && pending_rest == '0) state_d = INV;
      end
      INV: begin
        req_o = '1;
        we_o  = 1'b1;
        if (gnt_i) state_d = last_set ? DONE : READ;
      end
      DONE: begin
        flush_ack_o = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Payload is a decode of registered state only, so it cannot move while ready is low.
  always_comb begin
    addr_o    = (req_o != '0) ? index_q : '0;
    wb_addr_o = '0;
    wb_data_o = '0;
    if (state_q == WB) begin
      wb_addr_o = {tag_q[way_idx], index_q, {OFFSET_BITS{1'b0}}};
      wb_data_o = data_q[way_idx];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      index_q   <= '0;
      pending_q <= '0;
      for (int w = 0; w < SET_ASSOC; w++) begin
        tag_q[w]  <= '0;
        data_q[w] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: if (flush_i) index_q <= '0;
        LATCH: begin
          pending_q <= line_valid_i & line_dirty_i;
          for (int w = 0; w < SET_ASSOC; w++) begin
            tag_q[w]  <= line_tag_i[w*TAG_WIDTH +: TAG_WIDTH];
            data_q[w] <= line_data_i[w*LINE_WIDTH +: LINE_WIDTH];
          end
        end
        WB:  if (wb_ready_i) pending_q <= pending_rest;
        INV: if (gnt_i && !last_set) index_q <= index_q + INDEX_BITS'(1);
        default: ;
      endcase
    end
  end

`ifdef DCACHE_FLUSH_PERF_CNT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                  wb_count_o <= '0;
    else if (state_q == IDLE && flush_i)        wb_count_o <= '0;
    else if (wb_valid_o && wb_ready_i && wb_count_o != '1)
      wb_count_o <= wb_count_o + 32'd1;
  end
`endif

endmodule

// File: tb/tb_dcache_flush_ctrl.sv
// Bench for dcache_flush_ctrl: behavioural cache array answers SRAM reads, scoreboard checks writebacks.
module tb_dcache_flush_ctrl;

  localparam int WAYS = 8;
  localparam int SETS = 256;
  localparam int LW   = 128;
  localparam int TW   = 44;
  localparam int IB   = 8;
  localparam int OB   = 4;
  localparam int AW   = TW + IB + OB;

  logic                 clk = 1'b0;
  logic                 rst_i = 1'b1;
  logic                 flush_i = 1'b0;
  logic                 flush_ack_o, busy_o, we_o, wb_valid_o;
  logic [WAYS-1:0]      req_o;
  logic [IB-1:0]        addr_o;
  logic                 gnt_i = 1'b0;
  logic [WAYS-1:0]      line_valid_i = '0, line_dirty_i = '0;
  logic [WAYS*TW-1:0]   line_tag_i = '0;
  logic [WAYS*LW-1:0]   line_data_i = '0;
  logic                 wb_ready_i = 1'b0;
  logic [AW-1:0]        wb_addr_o;
  logic [LW-1:0]        wb_data_o;
`ifdef DCACHE_FLUSH_PERF_CNT_EN
  logic [31:0]          wb_count_o;
`endif

  always #5 clk = ~clk;

  dcache_flush_ctrl dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .flush_ack_o(flush_ack_o),
    .busy_o(busy_o), .req_o(req_o), .addr_o(addr_o), .we_o(we_o), .gnt_i(gnt_i),
    .line_valid_i(line_valid_i), .line_dirty_i(line_dirty_i), .line_tag_i(line_tag_i),
    .line_data_i(line_data_i), .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o)
`ifdef DCACHE_FLUSH_PERF_CNT_EN
    , .wb_count_o(wb_count_o)
`endif
  );

  // Behavioural cache contents
  logic [WAYS-1:0] m_valid [SETS];
  logic [WAYS-1:0] m_dirty [SETS];
  logic [TW-1:0]   m_tag   [SETS][WAYS];
  logic [LW-1:0]   m_data  [SETS][WAYS];

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [LW-1:0] data;
  } wb_t;
  wb_t exp_q[$];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic clear_mem();
    for (int s = 0; s < SETS; s++) begin
      m_valid[s] = '0;
      m_dirty[s] = WAYS'($urandom());
      for (int w = 0; w < WAYS; w++) begin
        m_tag[s][w]  = TW'({$urandom(), $urandom()});
        m_data[s][w] = rand_line();
      end
    end
  endtask

  task automatic rand_mem();
    clear_mem();
    for (int s = 0; s < SETS; s++) begin
      m_valid[s] = WAYS'($urandom()) & WAYS'($urandom());
      m_dirty[s] = WAYS'($urandom());
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_req"}, 64'(req_o), 64'd0);
    check({tag, "_addr"}, 64'(addr_o), 64'd0);
    check({tag, "_we"}, 64'(we_o), 64'd0);
    check({tag, "_busy"}, 64'(busy_o), 64'd0);
    check({tag, "_ack"}, 64'(flush_ack_o), 64'd0);
    check({tag, "_wbv"}, 64'(wb_valid_o), 64'd0);
    check({tag, "_wba"}, 64'(wb_addr_o), 64'd0);
    check({tag, "_wbd_nz"}, 64'(|wb_data_o), 64'd0);
  endtask

  // One flush, cycle 0 = IDLE cycle in which flush_i is sampled.
  // gmode/rmode: randomised grant/ready; stall_set/gstall: withheld grants on that set's READ;
  // rstall: ready withheld on the first wb cycles; abort_set: stop at first WB of that set.
  task automatic run_flush(input int gmode, input int rmode, input int stall_set, input int gstall,
                           input int rstall, input int abort_set, output int ack_cyc,
                           output int abort_cyc, output int nacc, output logic [AW-1:0] first_addr);
    int cyc = 0, rd_cnt = 0, inv_cnt = 0, bad = 0, acks = 0, stalls = 0, nwb_exp;
    int wb_bad = 0, busy_bad = 0, hold_bad = 0, gleft = gstall, rleft = rstall;
    int rd_idx = 0;
    logic rd_vld = 1'b0, prev_wait = 1'b0, g, rdy, exp_busy;
    logic [AW-1:0] prev_addr = '0;
    logic [LW-1:0] prev_data = '0;
    wb_t e;
    exp_q.delete();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++)
        if (m_valid[s][w] && m_dirty[s][w]) begin
          e.addr = {m_tag[s][w], IB'(s), OB'(0)};
          e.data = m_data[s][w];
          exp_q.push_back(e);
        end
    nwb_exp = exp_q.size();
    ack_cyc = -1; abort_cyc = -1; nacc = 0; first_addr = '0;
    @(negedge clk);
    flush_i = 1'b1;
    while (cyc < 20000) begin
      if (rd_vld) begin
        line_valid_i = m_valid[rd_idx];
        line_dirty_i = m_dirty[rd_idx];
        for (int w = 0; w < WAYS; w++) begin
          line_tag_i[w*TW +: TW]  = m_tag[rd_idx][w];
          line_data_i[w*LW +: LW] = m_data[rd_idx][w];
        end
      end else begin
        line_valid_i = WAYS'($urandom());
        line_dirty_i = WAYS'($urandom());
        for (int w = 0; w < WAYS; w++) begin
          line_tag_i[w*TW +: TW]  = TW'({$urandom(), $urandom()});
          line_data_i[w*LW +: LW] = rand_line();
        end
      end
      rd_vld = 1'b0;

      exp_busy = (cyc >= 1) && (ack_cyc < 0);
      if (busy_o !== exp_busy) busy_bad++;

      if (abort_set >= 0 && wb_valid_o && int'(wb_addr_o[OB +: IB]) == abort_set) begin
        abort_cyc  = cyc;
        wb_ready_i = 1'b0;
        gnt_i      = 1'b0;
        flush_i    = 1'b0;
        break;
      end

      if (wb_valid_o) begin
        if (prev_wait && (wb_addr_o !== prev_addr || wb_data_o !== prev_data)) hold_bad++;
        rdy = rmode ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (rleft > 0) begin rdy = 1'b0; rleft--; end
        if (!rdy) stalls++;
        else begin
          if (nacc == 0) first_addr = wb_addr_o;
          if (exp_q.size() == 0) wb_bad++;
          else begin
            e = exp_q.pop_front();
            if (e.addr !== wb_addr_o || e.data !== wb_data_o) wb_bad++;
          end
          nacc++;
        end
        prev_wait = !rdy; prev_addr = wb_addr_o; prev_data = wb_data_o;
        wb_ready_i = rdy;
      end else begin
        if (prev_wait) hold_bad++;
        prev_wait  = 1'b0;
        wb_ready_i = 1'($urandom());
      end

      if (req_o != '0) begin
        if (req_o !== '1) bad++;
        g = gmode ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (!we_o && int'(addr_o) == stall_set && gleft > 0) begin g = 1'b0; gleft--; end
        if (!g) stalls++;
        else if (we_o) begin
          if (int'(addr_o) != inv_cnt) bad++;
          m_valid[addr_o] = '0;
          m_dirty[addr_o] = '0;
          inv_cnt++;
        end else begin
          if (int'(addr_o) != rd_cnt || rd_cnt != inv_cnt) bad++;
          rd_cnt++;
          rd_vld = 1'b1;
          rd_idx = int'(addr_o);
        end
        gnt_i = g;
      end else begin
        if (we_o) bad++;
        gnt_i = 1'($urandom());
      end

      if (flush_ack_o) begin
        acks++;
        if (ack_cyc < 0) ack_cyc = cyc;
        flush_i = 1'b0;
      end
      if (ack_cyc >= 0 && cyc == ack_cyc + 2) break;
      cyc++;
      @(negedge clk);
    end
    gnt_i = 1'b0;
    wb_ready_i = 1'b0;
    flush_i = 1'b0;
    if (abort_set < 0) begin
      check("flush_completes", 64'(ack_cyc >= 0), 64'd1);
      check("sram_protocol_errs", 64'(bad), 64'd0);
      check("busy_errs", 64'(busy_bad), 64'd0);
      check("wb_hold_errs", 64'(hold_bad), 64'd0);
      check("wb_payload_errs", 64'(wb_bad), 64'd0);
      check("wb_count", 64'(nacc), 64'(nwb_exp));
      check("ack_pulses", 64'(acks), 64'd1);
      check("inv_sets", 64'(inv_cnt), 64'(SETS));
      check("ack_cycle_formula", 64'(ack_cyc), 64'(1 + 3 * SETS + nwb_exp + stalls));
    end else begin
      check("abort_reached", 64'(abort_cyc >= 0), 64'd1);
    end
  endtask

  typedef struct {
    int            set;
    logic [7:0]    valid;
    logic [7:0]    dirty;
    int            way_a;
    logic [TW-1:0] tag_a;
    int            way_b;
    logic [TW-1:0] tag_b;
    int            gstall;
    int            rstall;
    int            exp_wb;
    int            exp_ack;
    logic [AW-1:0] exp_first;
  } vec_t;

  initial begin
    vec_t vecs[7];
    int ack_cyc, abort_cyc, nacc;
    logic [AW-1:0] first;

    vecs[0] = '{0,   8'h00, 8'h00, 0, 44'h0,   0, 44'h0,   0, 0, 0, 769, 56'h0};
    vecs[1] = '{5,   8'h44, 8'h44, 2, 44'hABC, 6, 44'h123, 0, 0, 2, 771, 56'hABC050};
    vecs[2] = '{7,   8'h02, 8'h08, 1, 44'h111, 3, 44'h222, 0, 0, 0, 769, 56'h0};
    vecs[3] = '{5,   8'h44, 8'h44, 2, 44'hABC, 6, 44'h123, 0, 4, 2, 775, 56'hABC050};
    vecs[4] = '{10,  8'h01, 8'h01, 0, 44'hFFF, 0, 44'hFFF, 3, 0, 1, 773, 56'hFFF0A0};
    vecs[5] = '{255, 8'hFF, 8'hFF, 0, 44'h5A5, 7, 44'h3C3, 0, 0, 8, 777, 56'h5A5FF0};
    vecs[6] = '{0,   8'h80, 8'h80, 7, 44'h7,   7, 44'h7,   0, 0, 1, 770, 56'h7000};

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
`ifdef DCACHE_FLUSH_PERF_CNT_EN
    check("reset_wb_count", 64'(wb_count_o), 64'd0);
`endif
    rst_i = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      clear_mem();
      m_valid[vecs[i].set] = vecs[i].valid;
      m_dirty[vecs[i].set] = vecs[i].dirty;
      m_tag[vecs[i].set][vecs[i].way_a] = vecs[i].tag_a;
      m_tag[vecs[i].set][vecs[i].way_b] = vecs[i].tag_b;
      run_flush(0, 0, vecs[i].set, vecs[i].gstall, vecs[i].rstall, -1, ack_cyc, abort_cyc, nacc, first);
      check($sformatf("vec%0d_ack_cycle", i), 64'(ack_cyc), 64'(vecs[i].exp_ack));
      check($sformatf("vec%0d_wb_lines", i), 64'(nacc), 64'(vecs[i].exp_wb));
      check($sformatf("vec%0d_first_wb_addr", i), 64'(first), 64'(vecs[i].exp_first));
    end

    for (int r = 0; r < 3; r++) begin
      rand_mem();
      run_flush(1, 1, -1, 0, 0, -1, ack_cyc, abort_cyc, nacc, first);
    end

    // Grant stalled 3 cycles on set 10, then reset during the WB of set 20.
    clear_mem();
    m_valid[20] = 8'h11;
    m_dirty[20] = 8'h11;
    run_flush(0, 0, 10, 3, 0, 20, ack_cyc, abort_cyc, nacc, first);
    check("abort_wb_cycle", 64'(abort_cyc), 64'd66);
    rst_i = 1'b1;
    #1;
    check_outputs_zero("midflush_reset");
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    check_outputs_zero("post_reset_idle");
    run_flush(0, 0, -1, 0, 0, -1, ack_cyc, abort_cyc, nacc, first);
    check("restart_ack_cycle", 64'(ack_cyc), 64'd771);
    check("restart_wb_set", 64'(first[OB +: IB]), 64'd20);

`ifdef DCACHE_FLUSH_PERF_CNT_EN
    clear_mem();
    m_valid[3] = 8'h07;   m_dirty[3] = 8'h07;
    m_valid[100] = 8'h22; m_dirty[100] = 8'h22;
    m_valid[200] = 8'h50; m_dirty[200] = 8'h50;
    run_flush(0, 1, -1, 0, 0, -1, ack_cyc, abort_cyc, nacc, first);
    check("perf_count_7", 64'(wb_count_o), 64'd7);
    run_flush(0, 0, -1, 0, 0, -1, ack_cyc, abort_cyc, nacc, first);
    check("perf_count_0", 64'(wb_count_o), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
